// File: rtl/shiftreg_sched.sv
`timescale 1ns/1ps
// Two-requester round-robin scheduler feeding one word at a time LSB-first into an external shift register.
// Latency: gnt to done is WIDTH+2 cycles; throughput one word per WIDTH+2 cycles back-to-back.
// Backpressure: requests are only granted in IDLE; requesters hold req/data until their gnt pulse.
module shiftreg_sched #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             si,
    output logic             sh_en,
    input  logic [WIDTH-1:0] po,
    output logic             done,
    output logic [WIDTH-1:0] rdata,
    output logic             owner,
    output logic             mismatch
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] buffer;
    logic             gidx;
    logic             last_served;
    logic             any_req;
    logic             win;

    // Round-robin pick: a lone request wins, on contention the one not served last wins.
    always_comb begin
        any_req = req0 | req1;
        win     = (req0 & req1) ? ~last_served : req1;
    end

    // Next state plus the combinational grant and shift-interface outputs.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        sh_en     = 1'b0;
        si        = 1'b0;
        case (state)
            IDLE: begin
                // rst gating keeps grants low while reset is held.
                if (any_req && rst) begin
                    gnt0      = ~win;
                    gnt1      = win;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                sh_en = 1'b1;
                si    = buffer[cnt];
                if (cnt == CNT_LAST) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: take the granted word, count shifts, capture and compare the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            buffer      <= '0;
            gidx        <= 1'b0;
            last_served <= 1'b1;
            done        <= 1'b0;
            rdata       <= '0;
            owner       <= 1'b0;
            mismatch    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        buffer      <= win ? data1 : data0;
                        gidx        <= win;
                        last_served <= win;
                        cnt         <= '0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CW'(1);
                end
                CHECK: begin
                    rdata    <= po;
                    owner    <= gidx;
                    mismatch <= (po != buffer);
                    done     <= 1'b1;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shiftreg_sched.sv
`timescale 1ns/1ps
module tb_shiftreg_sched;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] data0, data1;
    logic         gnt0, gnt1, si, sh_en, done, owner, mismatch;
    logic [W-1:0] po, rdata;

    // Environment: the external shift register, with an optional stuck-at-0 mask on po.
    logic [W-1:0] sr    = '0;
    logic [W-1:0] fmask = '0;
    assign po = sr & ~fmask;

    shiftreg_sched #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .si(si), .sh_en(sh_en), .po(po),
        .done(done), .rdata(rdata), .owner(owner), .mismatch(mismatch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sh_en) sr <= {si, sr[W-1:1]};

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Event logs filled by the monitor, inspected by the directed scenarios.
    int       cyc = 0;
    int       g_cyc[$];
    bit       g_idx[$];
    int       d_cyc[$];
    bit [7:0] d_rdata[$];
    bit       d_own[$];
    bit       d_mis[$];
    bit       si_log[$];
    bit       last_g0 = 0, last_g1 = 0;

    task automatic clear_logs();
        g_cyc.delete(); g_idx.delete(); d_cyc.delete();
        d_rdata.delete(); d_own.delete(); d_mis.delete(); si_log.delete();
    endtask

    // Transaction-level model: t counts cycles since the grant edge (0 = free).
    int           m_t = 0;
    bit           m_last = 1;
    bit           m_who = 0;
    bit [W-1:0]   m_word = '0;
    bit           m_done = 0;
    bit [W-1:0]   m_rdata = '0;
    bit           m_owner = 0;
    bit           m_mis = 0;

    always @(negedge clk) begin
        bit          e_g0, e_g1, e_sh, e_si, win;
        bit [W+6:0]  e_vec;
        cyc++;
        last_g0 = gnt0;
        last_g1 = gnt1;
        if (gnt0) begin g_cyc.push_back(cyc); g_idx.push_back(1'b0); end
        if (gnt1) begin g_cyc.push_back(cyc); g_idx.push_back(1'b1); end
        if (sh_en) si_log.push_back(si);
        if (done) begin
            d_cyc.push_back(cyc); d_rdata.push_back(rdata);
            d_own.push_back(owner); d_mis.push_back(mismatch);
        end
        if (!rst) begin
            chk("reset_outputs", {gnt0, gnt1, sh_en, si, done, owner, mismatch, rdata}, '0);
            m_t = 0; m_last = 1; m_done = 0; m_rdata = '0; m_owner = 0; m_mis = 0;
        end else begin
            win  = (req0 && req1) ? !m_last : req1;
            e_g0 = (m_t == 0) && (req0 || req1) && !win;
            e_g1 = (m_t == 0) && (req0 || req1) && win;
            e_sh = (m_t >= 1) && (m_t <= W);
            e_si = e_sh ? m_word[m_t-1] : 1'b0;
            e_vec = {e_g0, e_g1, e_sh, e_si, m_done, m_owner, m_mis, m_rdata};
            chk("cycle_outputs", {gnt0, gnt1, sh_en, si, done, owner, mismatch, rdata}, e_vec);
            m_done = 0;
            if (e_g0 || e_g1) begin
                m_word = win ? data1 : data0;
                m_who  = win;
                m_last = win;
                m_t    = 1;
            end else if (m_t >= 1 && m_t <= W) begin
                m_t++;
            end else if (m_t == W + 1) begin
                m_t     = 0;
                m_done  = 1;
                m_rdata = m_word & ~fmask;
                m_owner = m_who;
                m_mis   = (m_rdata != m_word);
            end
        end
    end

    // Bounded waits: each loop ends at posedge+1; an expired bound is a failed comparison.
    task automatic wait_gnts(input int n, input string name);
        int k = 0;
        while (g_idx.size() < n && k < 200) begin @(posedge clk); #1; k++; end
        chk(name, g_idx.size(), n);
    endtask

    task automatic wait_dones(input int n, input string name);
        int k = 0;
        while (d_cyc.size() < n && k < 200) begin @(posedge clk); #1; k++; end
        chk(name, d_cyc.size(), n);
    endtask

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        bit [7:0] exp_si_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        bit [7:0] d_save;
        rst = 0; req0 = 0; req1 = 0; data0 = '0; data1 = '0;
        #1;
        step(3);

        // Reset, then contention held from reset and fairness over four transfers.
        req0 = 1; req1 = 1; data0 = 8'h3C; data1 = 8'hC3;
        #1;
        chk("rst_holds_gnt0", gnt0, 0);
        chk("rst_holds_gnt1", gnt1, 0);
        chk("rst_rdata", rdata, 0);
        step(1);
        clear_logs();
        rst = 1;
        wait_gnts(4, "contention_gnt_count");
        req0 = 0; req1 = 0;
        wait_dones(4, "contention_done_count");
        for (int i = 0; i < 4; i++) begin
            chk("fair_gnt_order", g_idx[i], i % 2);
            chk("fair_owner", d_own[i], i % 2);
            chk("fair_rdata", d_rdata[i], (i % 2) ? 8'hC3 : 8'h3C);
        end
        chk("gnt1_in_done_cycle", g_cyc[1], d_cyc[0]);
        step(3);

        // Single request of A5: serial pattern, latency, captured word.
        clear_logs();
        req0 = 1; data0 = 8'hA5;
        wait_gnts(1, "single_gnt");
        req0 = 0; data0 = 8'h00;
        wait_dones(1, "single_done");
        chk("single_si_count", si_log.size(), 8);
        for (int i = 0; i < 8; i++) chk("single_si_bit", si_log[i], exp_si_bits[i]);
        chk("single_latency", d_cyc[0] - g_cyc[0], 10);
        chk("single_rdata", d_rdata[0], 8'hA5);
        chk("single_owner", d_own[0], 0);
        chk("single_mismatch", d_mis[0], 0);
        step(2);

        // Late request: req1 raised mid-SHIFT is held off until the done/IDLE cycle.
        clear_logs();
        req0 = 1; data0 = 8'($urandom);
        wait_gnts(1, "late_first_gnt");
        req0 = 0;
        step(2);
        req1 = 1; data1 = 8'($urandom);
        #1;
        chk("late_no_gnt1", gnt1, 0);
        wait_gnts(2, "late_second_gnt");
        req1 = 0;
        wait_dones(2, "late_dones");
        chk("late_gnt1_idx", g_idx[1], 1);
        chk("late_gnt1_at_done", g_cyc[1], d_cyc[0]);
        step(2);

        // Stuck-at-0 on po[3] with FF from requester 1.
        clear_logs();
        fmask = 8'h08;
        req1 = 1; data1 = 8'hFF;
        wait_gnts(1, "fault_gnt");
        req1 = 0;
        wait_dones(1, "fault_done");
        chk("fault_rdata", d_rdata[0], 8'hF7);
        chk("fault_mismatch", d_mis[0], 1);
        chk("fault_owner", d_own[0], 1);
        step(2);
        fmask = '0;

        // Asynchronous reset in the 4th SHIFT cycle, then req1 alone after release.
        req0 = 1; data0 = 8'($urandom);
        clear_logs();
        wait_gnts(1, "abort_gnt");
        req0 = 0;
        step(3);
        #1;
        chk("abort_pre_sh_en", sh_en, 1);
        clear_logs();
        rst = 0;
        #1;
        chk("abort_sh_en_drop", sh_en, 0);
        chk("abort_si_drop", si, 0);
        chk("abort_done_low", done, 0);
        step(2);
        req1 = 1; data1 = 8'($urandom); d_save = data1;
        step(1);
        rst = 1;
        #1;
        chk("release_gnt1", {gnt0, gnt1}, 2'b01);
        wait_gnts(1, "release_gnt_log");
        req1 = 0;
        wait_dones(1, "release_done_count");
        chk("release_owner", d_own[0], 1);
        chk("release_rdata", d_rdata[0], d_save);
        step(2);

        // Randomized traffic; requesters hold req/data until granted.
        for (int c = 0; c < 600; c++) begin
            if (last_g0) req0 = 0;
            if (last_g1) req1 = 0;
            if (!req0 && $urandom_range(3) == 0) begin req0 = 1; data0 = 8'($urandom); end
            if (!req1 && $urandom_range(3) == 0) begin req1 = 1; data1 = 8'($urandom); end
            step(1);
        end
        if (last_g0) req0 = 0;
        if (last_g1) req1 = 0;
        step(1);
        req0 = 0; req1 = 0;
        step(2 * (W + 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
